cfg_reg_arbiter: RTL and testbench

- Owns the config/status register bank and shares its single access port between NUM_REQ requesters.
- Requester 0 is the SPI wrapper's register side; higher indices are on-chip masters such as sequencers and IRQ logic.
- Grants one transaction at a time using round-robin order and a valid/ready request handshake with a single-pulse response.
- Drives the flat config_regs vector to the datapath and samples the flat status_regs vector from it.

---
 rtl/cfg_reg_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/cfg_reg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cfg_reg_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_reg_pkg.sv
// Shared types and defaults for the config/status register arbiter.
package cfg_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_NUM_CFG    = 8;
  localparam int DEF_NUM_STATUS = 8;
  localparam int DEF_REG_WIDTH  = 8;
  localparam int DEF_ADDR_W     = 4;

  // The lock lives in the last config register.
  localparam int LOCK_BIT = 0;

  function automatic int lock_reg_idx(input int num_cfg);
    return num_cfg - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after last_grant+1 (mod NUM_REQ).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Config/status register bank shared round-robin between NUM_REQ requesters.
// Optional macro CFG_LOCK_EN: bit 0 of the last config reg blocks writes from requesters other than 0.
module cfg_reg_arbiter
  import cfg_reg_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_CFG    = DEF_NUM_CFG,
  parameter int NUM_STATUS = DEF_NUM_STATUS,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [REG_WIDTH-1:0]            rsp_rdata,
  output logic                            rsp_err,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [REG_WIDTH-1:0]  cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0]  cfg_d [NUM_CFG];
  logic [REG_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]      arb_grant;
  logic                  arb_valid;

  logic                  sel_valid;
  logic                  sel_write;
  logic [ADDR_W-1:0]     sel_addr;
  logic [REG_WIDTH-1:0]  sel_wdata;
  logic                  is_cfg;
  logic                  is_status;
  logic                  lock_block;
  logic                  wr_ok;
  logic                  acc_err;
  logic [REG_WIDTH-1:0]  cfg_rd;
  logic [REG_WIDTH-1:0]  status_rd;
  logic [REG_WIDTH-1:0]  acc_rdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Decode the granted requester's transaction against the address map.
  always_comb begin
    sel_valid = req_valid[grant_q];
    sel_write = req_write[grant_q];
    sel_addr  = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(grant_q)*REG_WIDTH +: REG_WIDTH];
    is_cfg    = int'(sel_addr) < NUM_CFG;
    is_status = (int'(sel_addr) >= NUM_CFG) && (int'(sel_addr) < NUM_CFG + NUM_STATUS);

    cfg_rd = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (int'(sel_addr) == k) cfg_rd = cfg_q[k];
    end
    status_rd = '0;
    for (int s = 0; s < NUM_STATUS; s++) begin
      if (int'(sel_addr) == NUM_CFG + s) status_rd = status_regs[s*REG_WIDTH +: REG_WIDTH];
    end

`ifdef CFG_LOCK_EN
    lock_block = cfg_q[lock_reg_idx(NUM_CFG)][LOCK_BIT] && (grant_q != '0);
`else
    lock_block = 1'b0;
`endif

    wr_ok   = sel_write && is_cfg && !lock_block;
    acc_err = !(is_cfg || is_status) || (sel_write && is_status) || (sel_write && is_cfg && lock_block);

    if (!(is_cfg || is_status)) acc_rdata = '0;
    else if (is_cfg)            acc_rdata = wr_ok ? sel_wdata : cfg_rd;
    else                        acc_rdata = status_rd;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cfg_d        = cfg_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A requester that withdraws before its accept forfeits the slot silently.
        if (sel_valid) begin
          rsp_rdata_d = acc_rdata;
          rsp_err_d   = acc_err;
          state_d     = RESP;
          if (wr_ok) begin
            for (int k = 0; k < NUM_CFG; k++) begin
              if (int'(sel_addr) == k) cfg_d[k] = sel_wdata;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cfg_q        <= cfg_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == ACCESS && sel_valid) req_ready[grant_q] = 1'b1;
    if (state_q == RESP)                rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
    assign config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_q[k];
  end

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Table-driven bench for cfg_reg_arbiter with a response scoreboard.
module tb_cfg_reg_arbiter;

  localparam int NR = 2;
  localparam int NC = 8;
  localparam int NS = 6;
  localparam int RW = 8;
  localparam int AW = 4;

  typedef struct {
    int         req;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         exp_err;
    bit         chk_rdata;
  } vec_t;

  typedef struct {
    int         req;
    logic [7:0] rdata;
    bit         err;
    bit         chk_rdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*RW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [RW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NC*RW-1:0]  config_regs;
  logic [NS*RW-1:0]  status_regs;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  logic [NC*RW-1:0] exp_cfg;

  always #5 clk = ~clk;

  cfg_reg_arbiter #(
    .NUM_REQ    (NR),
    .NUM_CFG    (NC),
    .NUM_STATUS (NS),
    .REG_WIDTH  (RW),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .config_regs (config_regs),
    .status_regs (status_regs)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_who", 64'(rsp_valid), 64'(1 << mon_e.req));
        if (mon_e.chk_rdata) checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        checkOutput("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clk);
    req_valid[v.req]           = 1'b1;
    req_write[v.req]           = v.wr;
    req_addr[v.req*AW +: AW]   = v.addr;
    req_wdata[v.req*RW +: RW]  = v.wdata;
    e.req = v.req; e.rdata = v.exp_rdata; e.err = v.exp_err; e.chk_rdata = v.chk_rdata;
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_ready[v.req] && lat < 8);
    checkOutput("ready_latency", 64'(lat), 64'd1);
    if (req_ready[v.req]) begin
      @(posedge clk);
      #1 req_valid[v.req] = 1'b0;
      @(negedge clk);
      checkOutput("rsp_latency", 64'(rsp_valid), 64'(1 << v.req));
    end else begin
      req_valid[v.req] = 1'b0;
    end
    if (v.wr && !v.exp_err && int'(v.addr) < NC) exp_cfg[int'(v.addr)*RW +: RW] = v.wdata;
    @(posedge clk);
    #1;
    checkOutput("config_regs", 64'(config_regs), 64'(exp_cfg));
  endtask

  // Requesters 0 and 1 both hold read requests until nrsp responses have appeared.
  task automatic runBoth(input int nrsp, input int first);
    exp_t e;
    int   seen;
    int   last_t;
    @(negedge clk);
    req_valid = '1;
    req_write = '0;
    req_addr  = {4'd10, 4'd9};
    for (int k = 0; k < nrsp; k++) begin
      e.req = (first + k) % 2;
      e.rdata = (e.req == 0) ? 8'h10 : 8'h20;
      e.err = 1'b0;
      e.chk_rdata = 1'b1;
      sb.push_back(e);
    end
    seen = 0;
    last_t = 0;
    for (int cyc = 0; cyc < 40 && seen < nrsp; cyc++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (seen > 0) checkOutput("rr_gap", 64'(cyc - last_t), 64'd3);
        last_t = cyc;
        seen++;
      end
    end
    req_valid = '0;
    checkOutput("rr_count", 64'(seen), 64'(nrsp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] seen_rsp;
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_cfg   = '0;
    for (int s = 0; s < NS; s++) status_regs[s*RW +: RW] = RW'(s * 16);

    vecs.push_back('{0, 1'b0, 4'd9,  8'h00, 8'h10, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b1, 4'd3,  8'hA5, 8'hA5, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b1, 4'd12, 8'h77, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1, 1'b0, 4'd15, 8'h00, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1, 1'b1, 4'd14, 8'h55, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{0, 1'b1, 4'd0,  8'h3C, 8'h3C, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b1, 4'd7,  8'hFE, 8'hFE, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b0, 4'd13, 8'h00, 8'h50, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b0, 4'd0,  8'h00, 8'h3C, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b0, 4'd8,  8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b1});
`ifdef CFG_LOCK_EN
    vecs.push_back('{0, 1'b1, 4'd7,  8'h01, 8'h01, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b1, 4'd2,  8'h33, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1, 1'b0, 4'd2,  8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b1, 4'd7,  8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b1, 4'd2,  8'h33, 8'h33, 1'b0, 1'b1});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_config", 64'(config_regs), 64'd0);
    checkOutput("reset_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("reset_err", 64'(rsp_err), 64'd0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset asserted while the write's response is on the port.
    @(negedge clk);
    req_valid[0]    = 1'b1;
    req_write[0]    = 1'b1;
    req_addr[3:0]   = 4'd1;
    req_wdata[7:0]  = 8'h22;
    @(negedge clk);
    checkOutput("rstseq_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cfg = '0;
    @(negedge clk);
    checkOutput("rstseq_config", 64'(config_regs), 64'd0);
    checkOutput("rstseq_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rstseq_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("rstseq_ready_after", 64'(req_ready), 64'd0);

    // Contention right after reset: requester 0 first, then strict alternation.
    runBoth(4, 0);

    // Requester 1 withdraws during ACCESS.
    @(negedge clk);
    req_valid[1]     = 1'b1;
    req_write[1]     = 1'b1;
    req_addr[7:4]    = 4'd5;
    req_wdata[15:8]  = 8'h99;
    @(negedge clk);
    checkOutput("abandon_ready_pre", 64'(req_ready), 64'd2);
    req_valid[1] = 1'b0;
    #1;
    checkOutput("abandon_ready", 64'(req_ready), 64'd0);
    seen_rsp = '0;
    repeat (4) begin
      @(negedge clk);
      seen_rsp = seen_rsp | 8'(rsp_valid) | 8'(req_ready);
    end
    checkOutput("abandon_norsp", 64'(seen_rsp), 64'd0);
    checkOutput("abandon_config", 64'(config_regs), 64'(exp_cfg));

    // Last grant stayed at 1, so requester 0 wins the next contention.
    runBoth(2, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
